// File: rtl/rv523_alu_pkg.sv
// Shared types for the serial ALU controller: op codes, FSM states and op helpers.
package rv523_alu_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_AND  = 3'd2,
      ALU_OR   = 3'd3,
      ALU_XOR  = 3'd4,
      ALU_NOR  = 3'd5,
      ALU_SLTU = 3'd6,
      ALU_RSVD = 3'd7
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ctrl_state_t;

   // The reserved code executes as NOR so the slice never sees it.
   function automatic alu_op_t op_normalize(input alu_op_t op);
      return (op == ALU_RSVD) ? ALU_NOR : op;
   endfunction

   // SUB and SLTU both run as A + ~B + 1.
   function automatic logic op_is_sub(input alu_op_t op);
      return (op == ALU_SUB) || (op == ALU_SLTU);
   endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Request/response handshake bundle between decode, the serial ALU controller and writeback.
interface serial_alu_ctrl_if
   import rv523_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
);

   logic             req_valid;
   logic             req_ready;
   alu_op_t          req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_zero;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_zero
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_zero
   );

endinterface

// File: rtl/serial_shreg.sv
// Right-shifting register with parallel load; serial data enters at the MSB, leaves at bit 0.
module serial_shreg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             shift_i,
   input  logic             ser_i,
   output logic [WIDTH-1:0] par_o,
   output logic             ser_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // Load wins over shift.
   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = load_val_i;
      end else if (shift_i) begin
         data_d = {ser_i, data_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign par_o = data_q;
   assign ser_o = data_q[0];

endmodule

// File: rtl/serial_alu_ctrl.sv
// Drives an external 1-bit ALU slice over WIDTH cycles, LSB first, to execute one full-width op.
module serial_alu_ctrl
   import rv523_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   serial_alu_ctrl_if.slave    alu_bus,
   output alu_op_t             slice_op_o,
   output logic                slice_a_o,
   output logic                slice_b_o,
   output logic                slice_cin_o,
   input  logic                slice_y_i,
   input  logic                slice_cout_i
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   ctrl_state_t      state_q, state_d;
   alu_op_t          op_q, op_d;
   logic             carry_q, carry_d;
   logic             zero_acc_q, zero_acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_zero_q, rsp_zero_d;

   logic             ab_load;
   logic             ab_shift;
   logic [WIDTH-1:0] b_load_val;
   logic             res_load;
   logic             res_shift;
   logic [WIDTH-1:0] res_load_val;

   logic             a_ser;
   logic             b_ser;
   logic [WIDTH-1:0] res_par;
   logic [WIDTH-1:0] a_par_unused;
   logic [WIDTH-1:0] b_par_unused;
   logic             res_ser_unused;

   serial_shreg #(.WIDTH(WIDTH)) u_a_shreg (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ab_load),
      .load_val_i (alu_bus.req_a),
      .shift_i    (ab_shift),
      .ser_i      (1'b0),
      .par_o      (a_par_unused),
      .ser_o      (a_ser)
   );

   // B is stored pre-inverted for SUB/SLTU so the slice sees ~B directly.
   serial_shreg #(.WIDTH(WIDTH)) u_b_shreg (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ab_load),
      .load_val_i (b_load_val),
      .shift_i    (ab_shift),
      .ser_i      (1'b0),
      .par_o      (b_par_unused),
      .ser_o      (b_ser)
   );

   serial_shreg #(.WIDTH(WIDTH)) u_res_shreg (
      .clk        (clk),
      .rst        (rst),
      .load_i     (res_load),
      .load_val_i (res_load_val),
      .shift_i    (res_shift),
      .ser_i      (slice_y_i),
      .par_o      (res_par),
      .ser_o      (res_ser_unused)
   );

   // Next-state and datapath control.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      carry_d      = carry_q;
      zero_acc_d   = zero_acc_q;
      cnt_d        = cnt_q;
      req_ready_d  = req_ready_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_zero_d   = rsp_zero_q;
      ab_load      = 1'b0;
      ab_shift     = 1'b0;
      b_load_val   = alu_bus.req_b;
      res_load     = 1'b0;
      res_shift    = 1'b0;
      res_load_val = '0;

      unique case (state_q)
         IDLE: begin
            if (alu_bus.req_valid) begin
               op_d        = op_normalize(alu_bus.req_op);
               ab_load     = 1'b1;
               b_load_val  = op_is_sub(alu_bus.req_op) ? ~alu_bus.req_b : alu_bus.req_b;
               carry_d     = op_is_sub(alu_bus.req_op);
               cnt_d       = '0;
               zero_acc_d  = 1'b0;
               req_ready_d = 1'b0;
               state_d     = RUN;
            end
         end

         RUN: begin
            ab_shift   = 1'b1;
            res_shift  = 1'b1;
            carry_d    = slice_cout_i;
            zero_acc_d = zero_acc_q | slice_y_i;
            cnt_d      = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               cnt_d       = '0;
               carry_d     = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = DONE;
               // SLTU: a clear final carry means A < B.
               if (op_q == ALU_SLTU) begin
                  res_shift    = 1'b0;
                  res_load     = 1'b1;
                  res_load_val = {{(WIDTH-1){1'b0}}, ~slice_cout_i};
                  rsp_zero_d   = slice_cout_i;
               end else begin
                  rsp_zero_d   = ~(zero_acc_q | slice_y_i);
               end
            end
         end

         DONE: begin
            if (alu_bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= ALU_ADD;
         carry_q     <= 1'b0;
         zero_acc_q  <= 1'b0;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         carry_q     <= carry_d;
         zero_acc_q  <= zero_acc_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_zero_q  <= rsp_zero_d;
      end
   end

   assign alu_bus.req_ready = req_ready_q;
   assign alu_bus.rsp_valid = rsp_valid_q;
   assign alu_bus.rsp_data  = res_par;
   assign alu_bus.rsp_zero  = rsp_zero_q;

   assign slice_op_o  = op_q;
   assign slice_a_o   = a_ser;
   assign slice_b_o   = b_ser;
   assign slice_cin_o = carry_q;

endmodule
